// File: rtl/bidir_dir_arbiter.sv
// bidir_dir_arbiter: owns the direction of one shared tristate link between
// side A (drives A->B) and side B (drives B->A). Every release passes through
// a Hi-Z dead time of TURN_CYC cycles. Ties are broken round-robin. A holder
// is forced off after MAX_HOLD cycles while the other side waits (0 = never).
// Optional build macro BIDIR_ARB_STATS_EN adds turn/preemption counters.
module bidir_dir_arbiter #(
   parameter int unsigned TURN_CYC = 2,
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic        req_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [1:0]  cfg,
`ifdef BIDIR_ARB_STATS_EN
   output logic [15:0] turn_count,
   output logic [7:0]  preempt_count,
`endif
   output logic        turn
);

   localparam int unsigned HOLD_W = 8;
   localparam int unsigned TURN_W = 4;
   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam bit PREEMPT_EN = (MAX_HOLD != 0);

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B, TURN} state_t;

   state_t              state, state_nxt, pick_c;
   logic                last_b, last_b_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
   logic [TURN_W-1:0]   turn_cnt, turn_nxt;
   logic                mine_c, other_c, preempt_c;

   // Arbitration pick for IDLE and the last dead-time cycle; ties go to the side not granted last.
   always_comb begin
      pick_c = IDLE;
      if (req_a && req_b)
         pick_c = last_b ? GNT_A : GNT_B;
      else if (req_a)
         pick_c = GNT_A;
      else if (req_b)
         pick_c = GNT_B;
   end

   // Next-state, hold and dead-time counter logic.
   always_comb begin
      state_nxt  = state;
      last_b_nxt = last_b;
      hold_nxt   = hold_cnt;
      turn_nxt   = turn_cnt;
      mine_c     = (state == GNT_A) ? req_a : req_b;
      other_c    = (state == GNT_A) ? req_b : req_a;
      preempt_c  = 1'b0;
      case (state)
         IDLE: state_nxt = pick_c;
         GNT_A, GNT_B: begin
            preempt_c = PREEMPT_EN && other_c && (hold_cnt == HOLD_LAST);
            if (preempt_c || !mine_c) begin
               state_nxt = TURN;
               turn_nxt  = TURN_LOAD;
            end else if (other_c) begin
               if (hold_cnt != {HOLD_W{1'b1}})
                  hold_nxt = hold_cnt + HOLD_W'(1);
            end else begin
               hold_nxt = '0;
            end
         end
         TURN: begin
            if (turn_cnt == '0)
               state_nxt = pick_c;
            else
               turn_nxt = turn_cnt - TURN_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
      if ((state_nxt == GNT_A || state_nxt == GNT_B) && state_nxt != state) begin
         last_b_nxt = (state_nxt == GNT_B);
         hold_nxt   = '0;
      end
   end

   // State register; reset drops straight to IDLE with no dead time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_b   <= 1'b1;
         hold_cnt <= '0;
         turn_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last_b   <= last_b_nxt;
         hold_cnt <= hold_nxt;
         turn_cnt <= turn_nxt;
      end
   end

   // Registered decode of the next state so outputs always match the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_a <= 1'b0;
         gnt_b <= 1'b0;
         cfg   <= 2'b00;
         turn  <= 1'b0;
      end else begin
         gnt_a <= (state_nxt == GNT_A);
         gnt_b <= (state_nxt == GNT_B);
         cfg   <= {state_nxt == GNT_A, state_nxt == GNT_B};
         turn  <= (state_nxt == TURN);
      end
   end

`ifdef BIDIR_ARB_STATS_EN
   // Saturating counts of dead-time entries and forced releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         turn_count    <= '0;
         preempt_count <= '0;
      end else begin
         if (state_nxt == TURN && state != TURN && turn_count != 16'hFFFF)
            turn_count <= turn_count + 16'd1;
         if (preempt_c && preempt_count != 8'hFF)
            preempt_count <= preempt_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bidir_dir_arbiter.sv
// Scoreboard bench for bidir_dir_arbiter: a link-ownership model predicts each
// cycle's outputs, a monitor compares them against the DUT.
module tb_bidir_dir_arbiter;

   localparam int unsigned TURN_CYC = 2;
   localparam int unsigned MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst, req_a, req_b;
   logic       gnt_a, gnt_b, turn;
   logic [1:0] cfg;
`ifdef BIDIR_ARB_STATS_EN
   logic [15:0] turn_count;
   logic [7:0]  preempt_count;
`endif

   bidir_dir_arbiter #(.TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .cfg(cfg),
`ifdef BIDIR_ARB_STATS_EN
      .turn_count(turn_count), .preempt_count(preempt_count),
`endif
      .turn(turn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] cfg;
      logic       ga;
      logic       gb;
      logic       turn;
      int         tcount;
      int         pcount;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Model state: who owns the link (0 none, 1 A, 2 B), Hi-Z cycles left,
   // side granted last, and how long the other side has been kept waiting.
   int owner = 0, dead = 0, last = 2, waited = 0, tcnt = 0, pcnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit a, input bit b);
      bit mine, other, forced;
      if (r) begin
         owner = 0; dead = 0; last = 2; waited = 0; tcnt = 0; pcnt = 0;
      end else if (owner != 0) begin
         mine   = (owner == 1) ? a : b;
         other  = (owner == 1) ? b : a;
         forced = (MAX_HOLD > 0) && other && (waited == int'(MAX_HOLD) - 1);
         if (forced || !mine) begin
            owner = 0;
            dead  = TURN_CYC;
            if (tcnt < 65535) tcnt++;
            if (forced && pcnt < 255) pcnt++;
         end else begin
            waited = other ? ((waited < 255) ? waited + 1 : 255) : 0;
         end
      end else if (dead > 1) begin
         dead--;
      end else begin
         dead = 0;
         if (a && b) owner = (last == 1) ? 2 : 1;
         else if (a) owner = 1;
         else if (b) owner = 2;
         if (owner != 0) begin
            last   = owner;
            waited = 0;
         end
      end
   endtask

   // Apply inputs away from the edge, advance the model at the edge, queue the expectation.
   task automatic step(input bit r, input bit a, input bit b);
      exp_t e;
      @(negedge clk);
      rst = r; req_a = a; req_b = b;
      @(posedge clk);
      model_edge(r, a, b);
      e.cfg    = {owner == 1, owner == 2};
      e.ga     = (owner == 1);
      e.gb     = (owner == 2);
      e.turn   = (dead > 0);
      e.tcount = tcnt;
      e.pcount = pcnt;
      q.push_back(e);
   endtask

   // Monitor: pop and compare one expectation per cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("cfg",   int'(cfg),   int'(e.cfg));
            check("gnt_a", int'(gnt_a), int'(e.ga));
            check("gnt_b", int'(gnt_b), int'(e.gb));
            check("turn",  int'(turn),  int'(e.turn));
            check("cfg_not_11", int'(cfg == 2'b11), 0);
            check("gnt_excl",   int'(gnt_a & gnt_b), 0);
`ifdef BIDIR_ARB_STATS_EN
            check("turn_count",    int'(turn_count),    e.tcount);
            check("preempt_count", int'(preempt_count), e.pcount);
`endif
         end
      end
   end

   initial begin
      bit a, b, r;
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
      // Reset with both requesting, then A wins the first tie.
      step(1, 1, 1);
      step(1, 1, 1);
      step(0, 1, 1);
      step(0, 1, 1);
      // Preemption: A holds, B waits until A is forced off.
      for (int i = 0; i < 12; i++) step(0, 1, 1);
      // Reset mid-grant, then release with both high.
      step(1, 1, 1);
      step(0, 1, 1);
      step(0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      // Single A transfer with clean release.
      for (int i = 0; i < 4; i++) step(0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      // Randomized phase with sticky requests and rare resets.
      a = 0; b = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) a = ~a;
         if ($urandom_range(0, 5) == 0) b = ~b;
         r = ($urandom_range(0, 149) == 0);
         step(r, a, b);
      end
      step(0, 0, 0);
      @(posedge clk);
      #2;
      check("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bidir_dir_arbiter.md
Name: bidir_dir_arbiter

Overview:
- Arbitrates ownership of one shared bidirectional tristate link between two requesters.
- Side A drives the link A->B; side B drives it B->A.
- Generates the 2-bit direction/enable word (cfg) consumed by the bidirectional tristate buffer instances.
- Guarantees a Hi-Z dead time on every release so both ends never drive at once.
- Provides round-robin fairness and optional hold-time preemption.

Parameters:
- TURN_CYC, 2, number of cycles cfg is held at 00 after any release; legal range 1..15.
- MAX_HOLD, 8, maximum grant cycles while the other side is waiting; 0 disables preemption; legal range 0..255.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  side A requests to drive A->B; level, held until done.
- req_b  input  1  side B requests to drive B->A; level, held until done.
- gnt_a  output  1  registered; side A owns the link.
- gnt_b  output  1  registered; side B owns the link.
- cfg  output  2  registered buffer config: 00 = both Hi-Z, 10 = A drives B, 01 = B drives A; 11 never produced.
- turn  output  1  registered; high during dead-time cycles.

Behaviour:
- Reset: synchronous on rst=1.
  - Next-edge state IDLE; cfg=00, gnt_a=0, gnt_b=0, turn=0.
  - last_grant=B, so A wins the first tie; hold_cnt=0, turn_cnt=0.
  - rst asserted mid-grant or mid-turn drops to IDLE/Hi-Z at that edge; no dead time is inserted.
- States:
  - IDLE: cfg=00, no grant.
  - GNT_A: cfg=10, gnt_a=1.
  - GNT_B: cfg=01, gnt_b=1.
  - TURN: cfg=00, turn=1.
- Outputs are a pure registered decode of state. gnt_x and cfg change on the same edge, so gnt_x=1 implies cfg matches.
- IDLE decision, in cycle n; the new state is visible at n+1:
  - Only req_a asserted -> GNT_A.
  - Only req_b asserted -> GNT_B.
  - Both asserted -> the side not equal to last_grant.
  - Neither asserted -> stay in IDLE.
  - Grant latency from IDLE is 1 cycle.
- On entry to a grant: last_grant is updated and hold_cnt is cleared.
- GNT_x, normal release: req_x sampled low -> TURN next cycle, with turn_cnt loaded to TURN_CYC-1.
- GNT_x, preemption (MAX_HOLD>0):
  - hold_cnt increments each cycle in GNT_x while the other req is high, saturating at 255.
  - hold_cnt clears while the other req is low.
  - When hold_cnt == MAX_HOLD-1 and the other req is still high, force -> TURN regardless of req_x.
  - The preempted side's gnt drops that edge. The preempted side must treat a gnt fall as loss of ownership and stop driving immediately.
- TURN:
  - turn_cnt decrements each cycle.
  - When turn_cnt==0, apply the IDLE decision in that cycle. The grant is therefore visible after exactly TURN_CYC Hi-Z cycles, with no extra IDLE cycle.
- Every release passes through TURN, including a same-side re-request; no back-to-back direction change ever occurs.
- Simultaneous events:
  - req_x drop and preemption in the same cycle: a single transition to TURN.
  - Requests arriving during TURN are only evaluated at turn_cnt==0.
- Invariants:
  - gnt_a & gnt_b == 0.
  - cfg != 11.
  - cfg=00 whenever turn=1.

Optional Feature:
- Macro: BIDIR_ARB_STATS_EN.
- When defined, adds the following:
  - Output port turn_count [15:0]: number of TURN entries, saturating at 16'hFFFF.
  - Output port preempt_count [7:0]: number of forced releases, saturating at 8'hFF.
  - Both counters are cleared by rst.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan (TURN_CYC=2, MAX_HOLD=4):
- Reset check: rst=1 for 2 cycles with req_a=req_b=1 -> cfg=00, gnt_a=gnt_b=0, turn=0 during reset. One cycle after rst falls: gnt_a=1, cfg=10.
- Single A transfer: req_a high at cycle 5 -> cycle 6 cfg=10. req_a low at cycle 10 -> cycles 11–12 cfg=00, turn=1; cycle 13 IDLE, cfg=00, turn=0.
- Tie and alternation: req_a and req_b held high, both releasing after 2 granted cycles -> cfg sequence 10,10,00,00,01,01,00,00,10; no cycle has cfg=11.
- Preemption: req_a held high permanently, req_b raised on the 2nd GNT_A cycle -> gnt_a falls after 4 cycles with req_b high; then 2 cycles of cfg=00; then gnt_b=1, cfg=01.
- Reset mid-grant: rst pulsed during GNT_B -> next cycle cfg=00, gnt_b=0, no turn cycles. After release with both requests high, A is granted.
- With BIDIR_ARB_STATS_EN: the alternation test run for 3 grants -> turn_count=3, preempt_count=0. The preemption test -> preempt_count=1.
